tdc_readout_ctrl: RTL and testbench

//  Read side of the TDC result buffer. The write side fills a result RAM with

---
 rtl/tdc_readout_if.sv | 22 ++
 rtl/tdc_readout_ctrl.sv | 142 ++++++++++++++
 tb/tb_tdc_readout_ctrl.sv | 235 +++++++++++++++++++++++
 3 files changed

// File: rtl/tdc_readout_if.sv
// RAM read port and byte-stream link between the TDC readout controller and its neighbours.
interface tdc_readout_if #(
    parameter int DATA_W = 16,
    parameter int ADDR_W = 8
);
    logic              rd_en;
    logic [ADDR_W-1:0] rd_addr;
    logic [DATA_W-1:0] rd_data;
    logic [7:0]        tx_dat;
    logic              tx_vld;
    logic              tx_rdy;

    modport master (
        output rd_en, rd_addr, tx_dat, tx_vld,
        input  rd_data, tx_rdy
    );

    modport slave (
        input  rd_en, rd_addr, tx_dat, tx_vld,
        output rd_data, tx_rdy
    );
endinterface

// File: rtl/tdc_readout_ctrl.sv
// Reads the TDC result RAM back and streams it as a framed, XOR-checked byte stream.
// Latency: first byte (header) is offered the cycle after the start edge; 2 idle cycles per word.
// Backpressure: each byte is held stable on tx_dat until tx_rdy; stalls never drop or repeat bytes.
module tdc_readout_ctrl #(
    parameter int         DATA_W   = 16,
    parameter int         ADDR_W   = 8,
    parameter logic [7:0] HDR_BYTE = 8'hA5
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start_reading,
    input  logic              writing,
    input  logic [ADDR_W:0]   wr_count,
    output logic              busy,
    output logic              done,
    output logic              read_err,
    tdc_readout_if.master     bus
);
    localparam int NB    = (DATA_W + 7) / 8;
    localparam int SH_W  = NB * 8;
    localparam int CNT_W = ADDR_W + 1;

    typedef enum logic [3:0] {
        IDLE, HDR, CNT_H, CNT_L, FETCH, WAIT_RD, SEND, CHK, DONE
    } state_t;

    state_t            state, state_nxt;
    logic              start_prev;
    logic              writing_prev;
    logic [CNT_W-1:0]  count;
    logic [CNT_W-1:0]  idx;
    logic [CNT_W-1:0]  idx_inc;
    logic [7:0]        chk;
    logic [SH_W-1:0]   shreg;
    logic [7:0]        bcnt;
    logic [15:0]       cnt16;
    logic              start;
    logic              start_ok;
    logic              err_set;
    logic              xfer;
    logic              tx_vld;
    logic [7:0]        tx_dat;
    logic              rd_en;

    assign start    = start_reading & ~start_prev;
    assign start_ok = (state == IDLE) & start & ~writing & (wr_count != '0);
    // Errors: a refused start in IDLE, any start while busy, or the writer starting mid-frame.
    assign err_set  = (start & ((state != IDLE) | writing | (wr_count == '0)))
                    | (writing & ~writing_prev & (state != IDLE));
    assign cnt16    = 16'(count);
    assign idx_inc  = idx + CNT_W'(1);
    assign xfer     = tx_vld & bus.tx_rdy;

    assign bus.tx_vld  = tx_vld;
    assign bus.tx_dat  = tx_dat;
    assign bus.rd_en   = rd_en;
    assign bus.rd_addr = idx[ADDR_W-1:0];
    assign busy        = (state != IDLE);
    assign done        = (state == DONE);

    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= IDLE;
            start_prev   <= 1'b0;
            writing_prev <= 1'b0;
            count        <= '0;
            idx          <= '0;
            chk          <= '0;
            shreg        <= '0;
            bcnt         <= '0;
            read_err     <= 1'b0;
        end else begin
            state        <= state_nxt;
            start_prev   <= start_reading;
            writing_prev <= writing;
            if (err_set) read_err <= 1'b1;
            case (state)
                IDLE: if (start_ok) begin
                    count <= wr_count;
                    idx   <= '0;
                    chk   <= '0;
                end
                CNT_H: if (xfer) chk <= chk ^ cnt16[15:8];
                CNT_L: if (xfer) chk <= chk ^ cnt16[7:0];
                WAIT_RD: begin
                    shreg <= SH_W'(bus.rd_data);
                    bcnt  <= 8'(NB - 1);
                end
                SEND: if (xfer) begin
                    chk   <= chk ^ shreg[SH_W-1 -: 8];
                    shreg <= shreg << 8;
                    if (bcnt == 8'd0) idx  <= idx_inc;
                    else              bcnt <= bcnt - 8'd1;
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        state_nxt = state;
        tx_vld    = 1'b0;
        tx_dat    = 8'h00;
        rd_en     = 1'b0;
        case (state)
            IDLE:    if (start_ok) state_nxt = HDR;
            HDR: begin
                tx_vld = 1'b1;
                tx_dat = HDR_BYTE;
                if (bus.tx_rdy) state_nxt = CNT_H;
            end
            CNT_H: begin
                tx_vld = 1'b1;
                tx_dat = cnt16[15:8];
                if (bus.tx_rdy) state_nxt = CNT_L;
            end
            CNT_L: begin
                tx_vld = 1'b1;
                tx_dat = cnt16[7:0];
                if (bus.tx_rdy) state_nxt = FETCH;
            end
            FETCH: begin
                rd_en     = 1'b1;
                state_nxt = WAIT_RD;
            end
            WAIT_RD: state_nxt = SEND;
            SEND: begin
                tx_vld = 1'b1;
                tx_dat = shreg[SH_W-1 -: 8];
                if (bus.tx_rdy && bcnt == 8'd0)
                    state_nxt = (idx_inc == count) ? CHK : FETCH;
            end
            CHK: begin
                tx_vld = 1'b1;
                tx_dat = chk;
                if (bus.tx_rdy) state_nxt = DONE;
            end
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end
endmodule

// File: tb/tb_tdc_readout_ctrl.sv
// Directed bench: frame bytes are predicted from RAM contents and compared on every transfer.
module tb_tdc_readout_ctrl;
    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       start_reading = 1'b0;
    logic       writing = 1'b0;
    logic [8:0] wr_count = '0;
    logic       busy, done, read_err;

    tdc_readout_if #(.DATA_W(16), .ADDR_W(8)) bus ();

    tdc_readout_ctrl #(.DATA_W(16), .ADDR_W(8), .HDR_BYTE(8'hA5)) dut (
        .clk           (clk),
        .rst           (rst),
        .start_reading (start_reading),
        .writing       (writing),
        .wr_count      (wr_count),
        .busy          (busy),
        .done          (done),
        .read_err      (read_err),
        .bus           (bus)
    );

    always #5 clk = ~clk;

    int         vectors = 0;
    int         miscompares = 0;
    logic [15:0] ram [256];
    logic [7:0]  exp_q [$];
    logic [7:0]  model_chk;
    int          done_cnt = 0;
    int          rx_cnt = 0;
    logic [7:0]  last_addr = '0;
    int          rdy_mode = 0;
    int          cyc = 0;
    logic        stalled_prev = 1'b0;
    logic [7:0]  prev_dat = '0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Synchronous RAM: data one cycle after the read strobe.
    always @(posedge clk) if (bus.rd_en) bus.rd_data <= ram[bus.rd_addr];

    initial bus.tx_rdy = 1'b1;
    always @(posedge clk) begin
        #1;
        bus.tx_rdy = (rdy_mode == 0) ? 1'b1 : ((cyc % 3) == 0);
        cyc++;
    end

    // Compare process: every accepted byte must be the next predicted one.
    always @(negedge clk) begin
        if (rst) begin
            stalled_prev = 1'b0;
        end else begin
            if (stalled_prev)
                check("stall_hold", {23'd0, bus.tx_vld, bus.tx_dat}, {23'd0, 1'b1, prev_dat});
            if (bus.tx_vld && bus.tx_rdy) begin
                rx_cnt++;
                if (exp_q.size() == 0) begin
                    vectors++;
                    miscompares++;
                    $display("FAIL unexpected_byte: got %0h expected none", bus.tx_dat);
                end else begin
                    check("tx_byte", {24'd0, bus.tx_dat}, {24'd0, exp_q.pop_front()});
                end
            end
            stalled_prev = bus.tx_vld & ~bus.tx_rdy;
            prev_dat     = bus.tx_dat;
            if (done) done_cnt++;
            if (bus.rd_en) last_addr = bus.rd_addr;
        end
    end

    // Frame model: header, 16-bit count, words MSB first, XOR of count and data bytes.
    task automatic build_frame(input int n);
        logic [15:0] c;
        logic [15:0] w;
        c = n[15:0];
        model_chk = c[15:8] ^ c[7:0];
        exp_q.push_back(8'hA5);
        exp_q.push_back(c[15:8]);
        exp_q.push_back(c[7:0]);
        for (int i = 0; i < n; i++) begin
            w = ram[i];
            exp_q.push_back(w[15:8]);
            exp_q.push_back(w[7:0]);
            model_chk = model_chk ^ w[15:8] ^ w[7:0];
        end
        exp_q.push_back(model_chk);
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        exp_q.delete();
        tick(2);
        rst = 1'b0;
    endtask

    task automatic pulse_start();
        start_reading = 1'b1;
        tick(1);
        start_reading = 1'b0;
    endtask

    task automatic wait_frame(input string name, input int budget);
        for (int n = 0; n < budget; n++) begin
            tick(1);
            if (done_cnt > 0) break;
        end
        tick(2);
        check({name, "_done_pulses"}, done_cnt, 1);
        check({name, "_bytes_left"}, exp_q.size(), 0);
        check({name, "_busy_after"}, {31'd0, busy}, 0);
    endtask

    logic [7:0] t1 [8];

    initial begin
        t1 = '{8'hA5, 8'h00, 8'h02, 8'h12, 8'h34, 8'hAB, 8'hCD, 8'h42};
        tick(1);
        check("rst_outputs", {busy, done, read_err, bus.tx_vld, bus.rd_en, bus.tx_dat}, 13'd0);
        tick(1);
        rst = 1'b0;
        tick(1);

        // 1: two words, always ready; start level held afterwards
        ram[0] = 16'h1234; ram[1] = 16'hABCD; wr_count = 9'd2;
        build_frame(2);
        for (int i = 0; i < 8; i++) check("model_t1", {24'd0, exp_q[i]}, {24'd0, t1[i]});
        done_cnt = 0;
        start_reading = 1'b1;
        tick(1);
        check("start_latency", {30'd0, busy, bus.tx_vld}, 2'b11);
        check("hdr_byte", {24'd0, bus.tx_dat}, 32'hA5);
        wait_frame("t1", 100);
        tick(5);
        check("held_no_restart", {31'd0, busy}, 0);
        check("t1_err", {31'd0, read_err}, 0);
        start_reading = 1'b0;
        tick(2);

        // 2: same frame under 1-in-3 ready; extra start edge mid-frame
        rdy_mode = 1;
        build_frame(2);
        done_cnt = 0;
        pulse_start();
        tick(4);
        pulse_start();
        check("start_while_busy_err", {31'd0, read_err}, 1);
        wait_frame("t2", 200);
        rdy_mode = 0;
        do_reset();
        check("err_cleared_by_rst", {31'd0, read_err}, 0);

        // 3: start while writer busy
        writing = 1'b1;
        pulse_start();
        tick(4);
        check("t3_busy", {31'd0, busy}, 0);
        check("t3_err", {31'd0, read_err}, 1);
        writing = 1'b0;
        tick(3);
        check("t3_err_sticky", {31'd0, read_err}, 1);
        do_reset();

        // 4: empty buffer
        wr_count = 9'd0;
        pulse_start();
        tick(4);
        check("t4_busy", {31'd0, busy}, 0);
        check("t4_err", {31'd0, read_err}, 1);
        do_reset();

        // 5: full buffer, RAM[i]=i
        for (int i = 0; i < 256; i++) ram[i] = 16'(i);
        wr_count = 9'd256;
        build_frame(256);
        check("model_t5_chk", {24'd0, model_chk}, 32'h01);
        check("model_t5_len", exp_q.size(), 516);
        check("model_t5_cnt", {16'd0, exp_q[1], exp_q[2]}, 32'h0100);
        done_cnt = 0;
        pulse_start();
        wait_frame("t5", 3000);
        check("t5_last_addr", {24'd0, last_addr}, 32'hFF);
        check("t5_err", {31'd0, read_err}, 0);

        // 6: reset after third byte, then a clean frame with writer rising mid-frame
        ram[0] = 16'h1234; ram[1] = 16'hABCD; wr_count = 9'd2;
        build_frame(2);
        rx_cnt = 0;
        pulse_start();
        for (int n = 0; n < 50; n++) begin
            @(posedge clk);
            #2;
            if (rx_cnt >= 3) break;
        end
        check("t6_three_bytes", rx_cnt, 3);
        rst = 1'b1;
        exp_q.delete();
        tick(1);
        check("t6_abort", {30'd0, bus.tx_vld, busy}, 0);
        rst = 1'b0;
        tick(1);
        build_frame(2);
        done_cnt = 0;
        pulse_start();
        tick(2);
        writing = 1'b1;
        wr_count = 9'd5;
        wait_frame("t6", 100);
        check("t6_writing_err", {31'd0, read_err}, 1);
        writing = 1'b0;

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end
endmodule
